load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512: size of the byte-addressed data memory being read.
REQ-002 SHALL have a single clock, clk; reset is synchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  64  byte address of the least-significant byte.
- req_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- mem_rd_en  out  1  byte read strobe to memory.
- mem_addr  out  64  byte address of the read.
- mem_rd_data  in  8  byte returned by memory, valid the cycle after the strobe.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  64  assembled, extended result.
- resp_err  out  1  request was illegal or out of range.

Function
REQ-004 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-005 SHALL derive the byte count N from req_funct3: 1 for B/BU, 2 for H/HU, 4 for W/WU, 8 for D.
REQ-006 SHALL flag an error when funct3 = 111 or req_addr + N - 1 >= MEM_BYTES, computed without 64-bit overflow wrap.
REQ-007 On an error, SHALL issue no mem_rd_en and SHALL assert resp_valid=1, resp_err=1, resp_data=0 in the cycle after acceptance.
REQ-008 On a legal request, SHALL assert mem_rd_en with mem_addr = req_addr + i for i = 0..N-1 in consecutive cycles 1..N after acceptance.
REQ-009 SHALL capture each mem_rd_data byte one cycle after its strobe into byte lane i of the result (little-endian: lane i = bits 8i+7:8i).
REQ-010 SHALL assert resp_valid in cycle N+2 after acceptance (LB: cycle 3; LD: cycle 10).
REQ-011 SHALL sign-extend bit 8N-1 into bits 63:8N for LB/LH/LW, and zero-extend for LBU/LHU/LWU; LD SHALL have no extension.
REQ-012 SHALL hold resp_valid, resp_data and resp_err stable until a rising edge with resp_ready=1, then return to IDLE on that edge.
REQ-013 SHALL NOT accept a new request in the same cycle a response retires; req_ready rises the cycle after.
REQ-014 SHALL use the FSM states IDLE, ISSUE, DRAIN, RESP with these transitions:
- IDLE->ISSUE on a legal accept.
- IDLE->RESP on an erroneous accept.
- ISSUE->DRAIN after the Nth strobe.
- DRAIN->RESP after the last capture.
- RESP->IDLE on resp_ready.
REQ-015 SHALL keep mem_rd_en=0 and mem_addr=0 outside ISSUE.
REQ-016 SHALL latch req_addr and req_funct3 at acceptance; request inputs SHALL be ignored outside IDLE.

Reset
REQ-017 While reset=1 at a rising edge, SHALL enter IDLE and drive req_ready=1, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0.
REQ-018 Reset mid-operation SHALL abandon the load with no further strobes and no response; in-flight mem_rd_data SHALL be ignored.

Structure
REQ-019 Shared package load_pkg SHALL hold the funct3 encodings, the FSM state enum, and the funct3-to-byte-count function.
REQ-020 A combinational sub-module load_extend SHALL perform the size/sign extension of REQ-011; all sequencing SHALL stay in load_unit.

Verification
REQ-021 The bench SHALL use a byte memory model with 1-cycle read latency, preloaded as listed, and SHALL cover:
- mem[16..23]=01..08, LD 16 -> resp_data 0x0807060504030201; strobes at addresses 16..23 in cycles 1..8; resp_valid in cycle 10; resp_err 0.
- mem[5]=0x80: LB 5 -> 0xFFFFFFFFFFFFFF80; LBU 5 -> 0x0000000000000080; resp_valid in cycle 3.
- mem[508..511]=0xEF,0xBE,0xAD,0xDE: LW 508 -> 0xFFFFFFFFDEADBEEF; LWU 508 -> 0x00000000DEADBEEF; LD 508 -> resp_err 1, data 0, no strobes, resp_valid in cycle 1.
- funct3=111 at address 0 -> resp_err 1 in cycle 1; req_addr=0xFFFFFFFFFFFFFFFF with LH -> resp_err 1 (no wrap).
- LH 16 with resp_ready held low 3 cycles -> resp_data 0x0201 stable and req_ready 0 throughout; IDLE and req_ready 1 the cycle after resp_ready is sampled 1.
- reset=1 in cycle 4 of an LD -> next cycle mem_rd_en 0, resp_valid 0, req_ready 1; a following LB 5 returns the correct value.

Source files
------------

// File: rtl/load_pkg.sv
// load_pkg: shared funct3 encodings, FSM states and size decode for the load unit
package load_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  function automatic logic [3:0] f3_bytes(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'd1 : f3[1:0] == 2'b01 ? 4'd2 : f3[1:0] == 2'b10 ? 4'd4 : 4'd8;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: sign/zero extension of an assembled little-endian load result
module load_extend
  import load_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);
  logic w_sx;
  assign w_sx = ~i_funct3[2];
  assign o_data = i_funct3 == F3_LD ? i_data :
                  i_funct3[1:0] == 2'b00 ? {{56{w_sx & i_data[7]}}, i_data[7:0]} :
                  i_funct3[1:0] == 2'b01 ? {{48{w_sx & i_data[15]}}, i_data[15:0]} :
                  i_funct3[1:0] == 2'b10 ? {{32{w_sx & i_data[31]}}, i_data[31:0]} : i_data;
endmodule

// File: rtl/load_unit.sv
// load_unit: byte-serial load sequencer with range check and size/sign extension
module load_unit
  import load_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_rd_en,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err
);
  state_t      r_state, w_next;
  logic [63:0] r_addr, r_data, w_ext;
  logic [2:0]  r_f3, r_idx, r_cap_idx;
  logic        r_err, r_cap_en, w_accept, w_err, w_last;
  logic [3:0]  w_n;
  logic [64:0] w_end;
  assign w_accept = r_state == IDLE && req_valid;
  assign w_end = {1'b0, req_addr} + 65'(f3_bytes(req_funct3));
  assign w_err = req_funct3 == F3_ILL || w_end > 65'(MEM_BYTES);
  assign w_n = f3_bytes(r_f3);
  assign w_last = {1'b0, r_idx} == w_n - 4'd1;
  assign req_ready = r_state == IDLE;
  assign mem_rd_en = r_state == ISSUE;
  assign mem_addr = r_state == ISSUE ? r_addr + {61'd0, r_idx} : '0;
  assign resp_valid = r_state == RESP;
  assign resp_err = r_state == RESP && r_err;
  assign resp_data = r_state == RESP && !r_err ? w_ext : '0;
  load_extend u_ext (.i_data(r_data), .i_funct3(r_f3), .o_data(w_ext));
  // next state: DRAIN lasts one cycle because the final byte lands there
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? (w_err ? RESP : ISSUE) : IDLE;
      ISSUE:   w_next = w_last ? DRAIN : ISSUE;
      DRAIN:   w_next = RESP;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // state, request latch, strobe index and byte capture one cycle behind each strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_f3      <= '0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_state   <= w_next;
      r_cap_en  <= r_state == ISSUE;
      r_cap_idx <= r_idx;
      if (w_accept) begin
        r_addr <= req_addr;
        r_f3   <= req_funct3;
        r_err  <= w_err;
        r_data <= '0;
        r_idx  <= '0;
      end
      if (r_state == ISSUE) r_idx <= r_idx + 3'd1;
      if (r_cap_en) r_data[{r_cap_idx, 3'b000} +: 8] <= mem_rd_data;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: randomized and directed checks of load_unit against a byte-memory reference
module tb_load_unit;
  localparam int MEM = 512;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, mem_rd_en, resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] req_addr = '0, mem_addr, resp_data;
  logic [2:0]  req_funct3 = '0;
  logic [7:0]  mem_rd_data = '0;
  logic [7:0]  mem [MEM];
  int          errors = 0, checks = 0;
  load_unit #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  // byte memory, one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[8:0]];
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic void ref_load(input logic [63:0] a, input logic [2:0] f,
                                   output logic [63:0] d, output logic e, output int n);
    logic [64:0] last;
    n = 1 << (int'(f) % 4);
    last = {1'b0, a} + 65'(n);
    e = (f == 3'd7) || (last > 65'(MEM));
    d = '0;
    if (!e) begin
      for (int i = 0; i < n; i++) d = d | (64'(mem[int'(a) + i]) << (8 * i));
      if (f < 3'd3 && d[8 * n - 1]) d = d | (~64'd0 << (8 * n));
    end
  endfunction
  task automatic run_load(input logic [63:0] a, input logic [2:0] f, output logic [63:0] d,
                          output logic e, output int lat, output int ns, output int first,
                          output int last, output logic aok);
    d = '0; e = 1'b0; lat = -1; ns = 0; first = 0; last = 0; aok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_funct3 = f;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_funct3 = 3'($urandom);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (ns == 0) first = c;
        last = c;
        if (mem_addr !== a + 64'(ns)) aok = 1'b0;
        ns++;
      end
      if (resp_valid) begin
        lat = c; d = resp_data; e = resp_err;
      end
    end
  endtask
  task automatic retire();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en got=%b want=0", mem_rd_en); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_data !== 64'd0) begin errors++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    reset = 1'b0;
  endtask
  task automatic test_ld();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la;
    run_load(64'd16, 3'b011, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'h0807060504030201) begin errors++; $display("FAIL ld_data got=%h want=0807060504030201", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ld_err got=%b want=0", e); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL ld_latency got=%0d want=10", lat); end
    checks++; if (ns !== 8 || fi !== 1 || la !== 8) begin errors++; $display("FAIL ld_strobes got n=%0d first=%0d last=%0d want 8/1/8", ns, fi, la); end
    checks++; if (aok !== 1'b1) begin errors++; $display("FAIL ld_strobe_addr got=%b want=1", aok); end
    retire();
  endtask
  task automatic test_sign();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la;
    run_load(64'd5, 3'b000, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_data got=%h want=ffffffffffffff80", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got=%0d want=3", lat); end
    retire();
    run_load(64'd5, 3'b100, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'h80) begin errors++; $display("FAIL lbu_data got=%h want=0000000000000080", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lbu_latency got=%0d want=3", lat); end
    retire();
  endtask
  task automatic test_top_of_mem();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la;
    run_load(64'd508, 3'b010, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'hFFFFFFFFDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_top got=%h err=%b want=ffffffffdeadbeef err=0", d, e); end
    retire();
    run_load(64'd508, 3'b110, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'h00000000DEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lwu_top got=%h err=%b want=00000000deadbeef err=0", d, e); end
    retire();
    run_load(64'd508, 3'b011, d, e, lat, ns, fi, la, aok);
    checks++; if (e !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL ld_oob got err=%b data=%h want err=1 data=0", e, d); end
    checks++; if (ns !== 0 || lat !== 1) begin errors++; $display("FAIL ld_oob_timing got strobes=%0d lat=%0d want 0/1", ns, lat); end
    retire();
  endtask
  task automatic test_illegal();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la;
    run_load(64'd0, 3'b111, d, e, lat, ns, fi, la, aok);
    checks++; if (e !== 1'b1 || lat !== 1 || ns !== 0) begin errors++; $display("FAIL illegal_f3 got err=%b lat=%0d strobes=%0d want 1/1/0", e, lat, ns); end
    retire();
    run_load(64'hFFFFFFFFFFFFFFFF, 3'b001, d, e, lat, ns, fi, la, aok);
    checks++; if (e !== 1'b1 || ns !== 0 || d !== 64'd0) begin errors++; $display("FAIL wrap_lh got err=%b strobes=%0d data=%h want 1/0/0", e, ns, d); end
    retire();
  endtask
  task automatic test_backpressure();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la;
    run_load(64'd16, 3'b001, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'h0201 || lat !== 4) begin errors++; $display("FAIL lh_data got=%h lat=%0d want 0201 lat=4", d, lat); end
    req_valid = 1'b1; req_addr = 64'd0; req_funct3 = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h0201 || req_ready !== 1'b0 || resp_err !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got valid=%b data=%h ready=%b err=%b want 1/0201/0/0", k, resp_valid, resp_data, req_ready, resp_err);
      end
    end
    retire();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL after_retire got ready=%b rd_en=%b valid=%b want 1/0/0", req_ready, mem_rd_en, resp_valid);
    end
  endtask
  task automatic test_reset_mid();
    logic [63:0] d; logic e, aok; int lat, ns, fi, la, stray;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'd16; req_funct3 = 3'b011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_rd_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got rd_en=%b valid=%b ready=%b want 0/0/1", mem_rd_en, resp_valid, req_ready);
    end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_rd_en || resp_valid) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_reset_quiet got=%0d events want=0", stray); end
    run_load(64'd5, 3'b000, d, e, lat, ns, fi, la, aok);
    checks++; if (d !== 64'hFFFFFFFFFFFFFF80 || lat !== 3) begin errors++; $display("FAIL post_reset_lb got=%h lat=%0d want ffffffffffffff80 lat=3", d, lat); end
    retire();
  endtask
  task automatic test_random();
    logic [63:0] a, d, ed; logic [2:0] f; logic e, ee, aok; int lat, ns, fi, la, n, sel;
    for (int i = 0; i < MEM; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      a = sel < 6 ? 64'($urandom_range(0, MEM - 1)) : sel < 9 ? 64'($urandom_range(MEM - 9, MEM - 1)) : {$urandom, $urandom};
      f = 3'($urandom);
      ref_load(a, f, ed, ee, n);
      run_load(a, f, d, e, lat, ns, fi, la, aok);
      checks++; if (d !== ed || e !== ee) begin errors++; $display("FAIL rand_%0d a=%h f=%0d got=%h err=%b want=%h err=%b", t, a, f, d, e, ed, ee); end
      checks++; if (lat !== (ee ? 1 : n + 2) || ns !== (ee ? 0 : n) || aok !== 1'b1) begin
        errors++; $display("FAIL rand_seq_%0d got lat=%0d strobes=%0d addr_ok=%b want lat=%0d strobes=%0d", t, lat, ns, aok, ee ? 1 : n + 2, ee ? 0 : n);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      retire();
    end
  endtask
  initial begin
    for (int i = 0; i < MEM; i++) mem[i] = 8'd0;
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
    mem[5] = 8'h80;
    mem[508] = 8'hEF; mem[509] = 8'hBE; mem[510] = 8'hAD; mem[511] = 8'hDE;
    test_reset();
    test_ld();
    test_sign();
    test_top_of_mem();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
